// File: rtl/vigenere_stream_cipher.sv
// Vigenere encrypt/decrypt engine for a streaming ASCII character path.
// Runtime-loadable key; letters are shifted (case preserved), the key advances only on letters.
module vigenere_stream_cipher #(
    parameter int MAX_KEY_LEN   = 8,
    parameter bit PASS_NONALPHA = 1'b1,
    parameter int IDX_W         = $clog2(MAX_KEY_LEN)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     key_load,
    input  logic [8*MAX_KEY_LEN-1:0] key_in,
    input  logic [IDX_W:0]           key_len_in,
    input  logic                     decrypt,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               char_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               char_out,
    output logic [IDX_W-1:0]         key_idx
);

    localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(MAX_KEY_LEN);

    // Handshake: a transfer happens on a posedge where valid && ready are both high.
    // The producer keeps valid and data stable until that edge; ready may depend on valid.

    logic [4:0]     key_shift [MAX_KEY_LEN];
    logic [IDX_W:0] key_len;

    logic           accept;
    logic           is_upper;
    logic           is_lower;
    logic           is_letter;
    logic [7:0]     base;
    logic [4:0]     p;
    logic [4:0]     k;
    logic [5:0]     sum;
    logic [5:0]     r;
    logic [7:0]     result;
    logic [IDX_W:0] len_clamped;
    logic           idx_wrap;

    function automatic logic [4:0] shift_of(input logic [7:0] c);
        if (c >= 8'd65 && c <= 8'd90)
            return 5'(c - 8'd65);
        else if (c >= 8'd97 && c <= 8'd122)
            return 5'(c - 8'd97);
        else
            return 5'd0;
    endfunction

    always_comb begin
        in_ready = !key_load && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        is_upper  = (char_in >= 8'd65) && (char_in <= 8'd90);
        is_lower  = (char_in >= 8'd97) && (char_in <= 8'd122);
        is_letter = is_upper || is_lower;
        base      = is_upper ? 8'd65 : 8'd97;
        // Letter offset fits in 5 bits, so modulo-32 subtraction on the low bits is exact.
        p         = char_in[4:0] - base[4:0];
        k         = key_shift[key_idx];
        if (decrypt)
            sum = {1'b0, p} + 6'd26 - {1'b0, k};
        else
            sum = {1'b0, p} + {1'b0, k};
        r = (sum >= 6'd26) ? (sum - 6'd26) : sum;
        if (is_letter)
            result = base + {2'b00, r};
        else if (PASS_NONALPHA)
            result = char_in;
        else
            result = 8'd32;
    end

    always_comb begin
        if (key_len_in == '0)
            len_clamped = (IDX_W+1)'(1);
        else if (key_len_in > LEN_MAX)
            len_clamped = LEN_MAX;
        else
            len_clamped = key_len_in;
        idx_wrap = ({1'b0, key_idx} == (key_len - 1'b1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            char_out  <= 8'd0;
            key_idx   <= '0;
            key_len   <= (IDX_W+1)'(1);
            for (int i = 0; i < MAX_KEY_LEN; i++)
                key_shift[i] <= 5'd0;
        end else begin
            if (key_load) begin
                for (int i = 0; i < MAX_KEY_LEN; i++)
                    key_shift[i] <= shift_of(key_in[8*i +: 8]);
                key_len <= len_clamped;
                key_idx <= '0;
            end else if (accept && is_letter) begin
                key_idx <= idx_wrap ? '0 : key_idx + 1'b1;
            end

            if (accept) begin
                char_out  <= result;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
